// File: rtl/input_pulse_catcher.sv
`timescale 1ns/1ps
// input_pulse_catcher: per-channel async edge capture, 2-flop sync,
// one-cycle hit, stretched out, dead time, saturating counters, pile-up.
// Ports: clk, rst (async, active-high), in[N] async inputs, en[N],
//   cnt_clr; hit[N], out[N], any_hit, hit_cnt[N*CNT_W], pileup[N].
module input_pulse_catcher #(
  parameter int N = 8,
  parameter logic [N-1:0] POLARITY = {N{1'b0}},
  parameter int STRETCH = 2,
  parameter int DEAD = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in,
  input  logic [N-1:0]     en,
  input  logic             cnt_clr,
  output logic [N-1:0]     hit,
  output logic [N-1:0]     out,
  output logic             any_hit,
  output logic [N*CNT_W-1:0] hit_cnt,
  output logic [N-1:0]     pileup
);

  localparam int BUSY = (STRETCH > DEAD) ? STRETCH : DEAD;
  localparam logic [7:0] ST8 = 8'(STRETCH);
  localparam logic [7:0] BS8 = 8'(BUSY);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic [N-1:0] cap;
  logic [N-1:0] cclk;
  logic [N-1:0] cclr;
  logic [N-1:0] s1;
  logic [N-1:0] s2;
  logic [N-1:0] s2d;
  logic [N-1:0] ack;
  logic [N-1:0] det;
  logic [N-1:0] acc;
  logic [N-1:0] pu;

  logic [7:0]       out_cnt  [N];
  logic [7:0]       busy_cnt [N];
  logic [CNT_W-1:0] cnt      [N];

  assign cclk = in ^ POLARITY;
  assign cclr = ack | {N{rst}};

  // Capture flop per channel: clocked by the input edge itself so
  // pulses shorter than a clk period are still caught; the registered
  // ack releases it once the event has crossed into the clk domain.
  for (genvar i = 0; i < N; i++) begin : g_cap
    logic c;
    always_ff @(posedge cclk[i] or posedge cclr[i]) begin
      if (cclr[i]) c <= 1'b0;
      else         c <= 1'b1;
    end
    assign cap[i] = c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= '0;
      s2  <= '0;
      s2d <= '0;
      ack <= '0;
    end else begin
      s1  <= cap;
      s2  <= s1;
      s2d <= s2;
      ack <= s2;
    end
  end

  assign det = s2 & ~s2d;

  always_comb begin
    acc = '0;
    pu  = '0;
    for (int i = 0; i < N; i++) begin
      acc[i] = det[i] & en[i] & (busy_cnt[i] == 8'd0);
      pu[i]  = det[i] & en[i] & (busy_cnt[i] != 8'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit     <= '0;
      any_hit <= 1'b0;
      pileup  <= '0;
      for (int i = 0; i < N; i++) begin
        out_cnt[i]  <= '0;
        busy_cnt[i] <= '0;
        cnt[i]      <= '0;
      end
    end else begin
      hit     <= acc;
      any_hit <= |hit;
      for (int i = 0; i < N; i++) begin
        if (acc[i])
          out_cnt[i] <= ST8;
        else if (out_cnt[i] != 8'd0)
          out_cnt[i] <= out_cnt[i] - 8'd1;

        if (acc[i])
          busy_cnt[i] <= BS8;
        else if (busy_cnt[i] != 8'd0)
          busy_cnt[i] <= busy_cnt[i] - 8'd1;

        // clear then increment when both land together
        if (acc[i]) begin
          if (cnt_clr)
            cnt[i] <= CNT_W'(1);
          else if (cnt[i] != CMAX)
            cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (cnt_clr) begin
          cnt[i] <= '0;
        end

        // a pile-up in the clear cycle still sets the flag
        if (pu[i])
          pileup[i] <= 1'b1;
        else if (cnt_clr)
          pileup[i] <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_out
    assign out[i] = (out_cnt[i] != 8'd0);
    assign hit_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end

endmodule

// File: tb/tb_input_pulse_catcher.sv
`timescale 1ns/1ps
// tb_input_pulse_catcher: scoreboard bench, expected hit cycles
// queued per channel at stimulus time and popped on each hit.
module tb_input_pulse_catcher;

  localparam int N  = 8;
  localparam int CW = 4;
  localparam logic [N-1:0] POL = 8'h02;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    in_s = '0;
  logic [N-1:0]    en_s = '1;
  logic            cnt_clr = 1'b0;
  logic [N-1:0]    hit;
  logic [N-1:0]    out;
  logic            any_hit;
  logic [N*CW-1:0] hit_cnt;
  logic [N-1:0]    pileup;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int expq [N][$];

  input_pulse_catcher #(
    .N(N), .POLARITY(POL), .STRETCH(2),
    .DEAD(8), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .in(in_s), .en(en_s),
    .cnt_clr(cnt_clr), .hit(hit), .out(out),
    .any_hit(any_hit), .hit_cnt(hit_cnt),
    .pileup(pileup)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] cnt(input int i);
    return hit_cnt[i*CW +: CW];
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (hit[i]) begin
        chk($sformatf("hit%0d_pending", i),
            64'(expq[i].size() > 0), 64'd1);
        if (expq[i].size() > 0)
          chk($sformatf("hit%0d_cyc", i),
              64'(cyc), 64'(expq[i].pop_front()));
      end
    end
  end

  task automatic pulse(input int ch, input bit a);
    @(negedge clk);
    if (a) expq[ch].push_back(cyc + 3);
    in_s[ch] = 1'b1;
    #3;
    in_s[ch] = 1'b0;
  endtask

  task automatic drive(input int ch, input logic v,
                       input bit a);
    @(negedge clk);
    if (a) expq[ch].push_back(cyc + 3);
    in_s[ch] = v;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    wait_n(3);
    chk("rst_hit", 64'(hit), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_any", 64'(any_hit), 64'd0);
    chk("rst_pu", 64'(pileup), 64'd0);
    chk("rst_cnt", 64'(hit_cnt), 64'd0);
    rst = 1'b0;
    wait_n(2);

    // narrow pulse on ch0
    pulse(0, 1'b1);
    wait_n(1);
    chk("cap0_set", 64'(dut.cap[0]), 64'd1);
    wait_n(1);
    chk("out0_pre", 64'(out[0]), 64'd0);
    wait_n(1);
    chk("out0_e2", 64'(out[0]), 64'd1);
    chk("any_e2", 64'(any_hit), 64'd0);
    wait_n(1);
    chk("out0_e3", 64'(out[0]), 64'd1);
    chk("any_e3", 64'(any_hit), 64'd1);
    chk("cap0_clr", 64'(dut.cap[0]), 64'd0);
    wait_n(1);
    chk("out0_e4", 64'(out[0]), 64'd0);
    chk("any_e4", 64'(any_hit), 64'd0);
    chk("cnt0", 64'(cnt(0)), 64'd1);
    wait_n(6);

    // falling-edge channel
    drive(1, 1'b1, 1'b0);
    wait_n(6);
    drive(1, 1'b0, 1'b1);
    wait_n(8);
    chk("cnt1", 64'(cnt(1)), 64'd1);

    // pile-up on ch2
    pulse(2, 1'b1);
    wait_n(5);
    pulse(2, 1'b0);
    wait_n(4);
    chk("pu2_set", 64'(pileup[2]), 64'd1);
    chk("cnt2_pu", 64'(cnt(2)), 64'd1);
    @(negedge clk) cnt_clr = 1'b1;
    @(negedge clk) cnt_clr = 1'b0;
    chk("cnt2_clr", 64'(cnt(2)), 64'd0);
    chk("pu2_clr", 64'(pileup[2]), 64'd0);
    wait_n(6);

    // disabled channel
    en_s[3] = 1'b0;
    pulse(3, 1'b0);
    wait_n(8);
    chk("cnt3_dis", 64'(cnt(3)), 64'd0);
    chk("pu3_dis", 64'(pileup[3]), 64'd0);
    en_s[3] = 1'b1;
    pulse(3, 1'b1);
    wait_n(8);
    chk("cnt3_en", 64'(cnt(3)), 64'd1);

    // saturation on ch5
    for (int k = 0; k < 17; k++) begin
      pulse(5, 1'b1);
      wait_n(13);
    end
    chk("cnt5_sat", 64'(cnt(5)), 64'd15);

    // clear coincident with accept
    pulse(5, 1'b1);
    wait_n(2);
    cnt_clr = 1'b1;
    wait_n(1);
    cnt_clr = 1'b0;
    wait_n(1);
    chk("cnt5_clracc", 64'(cnt(5)), 64'd1);
    chk("pu5", 64'(pileup[5]), 64'd0);
    chk("cnt0_clr", 64'(cnt(0)), 64'd0);
    wait_n(10);

    // clear coincident with pile-up on ch6
    pulse(6, 1'b1);
    wait_n(5);
    pulse(6, 1'b0);
    wait_n(2);
    cnt_clr = 1'b1;
    wait_n(1);
    cnt_clr = 1'b0;
    chk("pu6_clrset", 64'(pileup[6]), 64'd1);
    chk("cnt6_clr", 64'(cnt(6)), 64'd0);
    wait_n(12);

    // reset mid-stretch on ch4
    pulse(4, 1'b1);
    wait_n(3);
    chk("out4_hi", 64'(out[4]), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_hit", 64'(hit), 64'd0);
    chk("mrst_out", 64'(out), 64'd0);
    chk("mrst_any", 64'(any_hit), 64'd0);
    chk("mrst_pu", 64'(pileup), 64'd0);
    chk("mrst_cnt", 64'(hit_cnt), 64'd0);
    wait_n(2);
    rst = 1'b0;
    wait_n(2);
    pulse(4, 1'b1);
    wait_n(8);
    chk("cnt4_post", 64'(cnt(4)), 64'd1);
    wait_n(4);

    // all channels at once
    @(negedge clk);
    for (int i = 0; i < N; i++)
      expq[i].push_back(cyc + 3);
    in_s = '1;
    #3;
    in_s = '0;
    wait_n(10);
    for (int i = 0; i < N; i++)
      chk($sformatf("cnt%0d_all", i), 64'(cnt(i)),
          (i == 4) ? 64'd2 : 64'd1);

    wait_n(10);
    for (int i = 0; i < N; i++)
      chk($sformatf("q%0d_left", i),
          64'(expq[i].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
